mlp_seq_core: RTL and testbench

Parametrised, time-multiplexed two-layer perceptron core. It replaces the fixed 4-input / 8-hidden / 1-output network that uses hard-wired weights. Weights are runtime-loadable and signed. A single shared MAC is sequenced by an FSM. Hidden activations saturate, and an optional ReLU can be compiled in. The core sits between the chip's `ui_in`/`uio` pins and the output mux, and is controlled by a start/done handshake.

---
 rtl/mlp_seq_core.sv | 155 +++++++++++++++
 tb/tb_mlp_seq_core.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_seq_core.sv
// Time-multiplexed two-layer perceptron: one shared signed MAC walks the hidden layer, then the output layer.
// Define MLP_RELU_EN to apply ReLU to the saturated hidden activations (identity otherwise).
module mlp_seq_core #(
    parameter int N_IN  = 4,
    parameter int N_HID = 8,
    parameter int X_W   = 4,
    parameter int W_W   = 5,
    parameter int H_W   = 10,
    parameter int OUT_W = H_W + W_W + $clog2(N_HID),
    parameter int A_W   = $clog2(N_HID * N_IN + N_HID)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    wr_en_i,
    input  logic [A_W-1:0]          wr_addr_i,
    input  logic [W_W-1:0]          wr_data_i,
    input  logic                    start_i,
    input  logic [N_IN*X_W-1:0]     x_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic signed [OUT_W-1:0] y_o,
    output logic [1:0]              state_o
);

    localparam int N_W   = N_IN * N_HID + N_HID;
    localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int JW    = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int P_W   = X_W + 1 + W_W;
    localparam int ACC_W = P_W + $clog2(N_IN) + 1;
    localparam int Q_W   = H_W + W_W;
    localparam longint H_MAX = (longint'(1) <<< (H_W - 1)) - 1;
    localparam longint H_MIN = -(longint'(1) <<< (H_W - 1));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HID  = 2'd1,
        S_OUT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nx;

    logic signed [W_W-1:0]   w_mem [N_W];
    logic signed [H_W-1:0]   h_mem [N_HID];
    logic [N_IN*X_W-1:0]     x_reg;
    logic [IW-1:0]           cnt_i;
    logic [JW-1:0]           cnt_j;
    logic [A_W-1:0]          rd_addr;
    logic signed [ACC_W-1:0] acc, acc_sum;
    logic signed [OUT_W-1:0] yacc, yacc_sum;
    logic signed [P_W-1:0]   prod_h;
    logic signed [Q_W-1:0]   prod_o;
    logic signed [W_W-1:0]   w_rd;
    logic [X_W-1:0]          x_sel;
    logic                    last_i, last_j;

    function automatic logic signed [H_W-1:0] sat_h(input logic signed [ACC_W-1:0] a);
        longint v;
        v = longint'(a);
        if (v > H_MAX) v = H_MAX;
        if (v < H_MIN) v = H_MIN;
        return H_W'(v);
    endfunction

    function automatic logic signed [H_W-1:0] act_h(input logic signed [H_W-1:0] a);
`ifdef MLP_RELU_EN
        return a[H_W-1] ? '0 : a;
`else
        return a;
`endif
    endfunction

    // The read address simply counts through the weight map: hidden weights first, then v[0..N_HID-1].
    always_comb begin
        last_i   = (cnt_i == IW'(N_IN - 1));
        last_j   = (cnt_j == JW'(N_HID - 1));
        w_rd     = w_mem[rd_addr];
        x_sel    = x_reg[cnt_i*X_W +: X_W];
        prod_h   = $signed({1'b0, x_sel}) * w_rd;
        acc_sum  = ACC_W'(prod_h);
        if (cnt_i != '0) acc_sum = acc + ACC_W'(prod_h);
        prod_o   = h_mem[cnt_j] * w_rd;
        yacc_sum = OUT_W'(prod_o);
        if (cnt_j != '0) yacc_sum = yacc + OUT_W'(prod_o);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start_i) state_nx = S_HID;
            S_HID:  if (last_i && last_j) state_nx = S_OUT;
            S_OUT:  if (last_j) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state == S_HID) || (state == S_OUT);
        done_o  = (state == S_DONE);
        state_o = state;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int k = 0; k < N_W; k++) w_mem[k] <= '0;
            for (int k = 0; k < N_HID; k++) h_mem[k] <= '0;
            x_reg   <= '0;
            cnt_i   <= '0;
            cnt_j   <= '0;
            rd_addr <= '0;
            acc     <= '0;
            yacc    <= '0;
            y_o     <= '0;
        end else begin
            if (wr_en_i && !busy_o && (int'(wr_addr_i) < N_W))
                w_mem[wr_addr_i] <= wr_data_i;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        x_reg   <= x_i;
                        cnt_i   <= '0;
                        cnt_j   <= '0;
                        rd_addr <= '0;
                    end
                end
                S_HID: begin
                    acc     <= acc_sum;
                    rd_addr <= rd_addr + 1'b1;
                    if (last_i) begin
                        cnt_i        <= '0;
                        h_mem[cnt_j] <= act_h(sat_h(acc_sum));
                        cnt_j        <= last_j ? '0 : cnt_j + 1'b1;
                    end else begin
                        cnt_i <= cnt_i + 1'b1;
                    end
                end
                S_OUT: begin
                    yacc    <= yacc_sum;
                    rd_addr <= rd_addr + 1'b1;
                    cnt_j   <= last_j ? '0 : cnt_j + 1'b1;
                    // Result is published on entry to DONE so it is valid while done_o is high.
                    if (last_j) y_o <= yacc_sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_seq_core.sv
// Self-checking bench for mlp_seq_core: randomized and directed runs against an arithmetic network model.
module tb_mlp_seq_core;

    localparam int N_IN  = 4;
    localparam int N_HID = 8;
    localparam int X_W   = 4;
    localparam int W_W   = 5;
    localparam int H_W   = 10;
    localparam int OUT_W = 18;
    localparam int A_W   = 6;
    localparam int N_W   = N_IN * N_HID + N_HID;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_i = 1'b0;
    logic                    wr_en_i = 1'b0;
    logic [A_W-1:0]          wr_addr_i = '0;
    logic [W_W-1:0]          wr_data_i = '0;
    logic                    start_i = 1'b0;
    logic [N_IN*X_W-1:0]     x_i = '0;
    logic                    busy_o;
    logic                    done_o;
    logic signed [OUT_W-1:0] y_o;
    logic [1:0]              state_o;

    int checks = 0;
    int failures = 0;
    int wm[N_W];

    mlp_seq_core #(
        .N_IN(N_IN), .N_HID(N_HID), .X_W(X_W), .W_W(W_W), .H_W(H_W),
        .OUT_W(OUT_W), .A_W(A_W)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i), .start_i(start_i), .x_i(x_i), .busy_o(busy_o),
        .done_o(done_o), .y_o(y_o), .state_o(state_o)
    );

    function automatic int model_y(input logic [15:0] xv);
        int y;
        int s;
        y = 0;
        for (int j = 0; j < N_HID; j++) begin
            s = 0;
            for (int i = 0; i < N_IN; i++)
                s += int'(xv[i*X_W +: X_W]) * wm[j*N_IN+i];
            if (s > 511) s = 511;
            if (s < -512) s = -512;
`ifdef MLP_RELU_EN
            if (s < 0) s = 0;
`endif
            y += s * wm[N_IN*N_HID+j];
        end
        return y;
    endfunction

    task automatic do_reset();
        rst_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b1;
        for (int a = 0; a < N_W; a++) wm[a] = 0;
    endtask

    task automatic write_w(input int addr, input int val);
        wr_en_i   = 1'b1;
        wr_addr_i = addr[A_W-1:0];
        wr_data_i = val[W_W-1:0];
        @(posedge clk); #1;
        wr_en_i = 1'b0;
        if (addr < N_W) wm[addr] = val;
    endtask

    task automatic load_all(input int hw, input int ov);
        for (int a = 0; a < N_IN*N_HID; a++) write_w(a, hw);
        for (int a = N_IN*N_HID; a < N_W; a++) write_w(a, ov);
    endtask

    task automatic run_inf(input logic [15:0] xv, input int inj_cycle, input logic inj_start,
                           input logic inj_wr, input logic [A_W-1:0] inj_addr,
                           input logic [W_W-1:0] inj_data,
                           output int y, output int lat, output int bcnt, output logic [1:0] st1);
        x_i = xv;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        x_i = 16'($urandom);
        lat = 1;
        bcnt = 0;
        st1 = state_o;
        while (done_o !== 1'b1 && lat < 200) begin
            if (busy_o === 1'b1) bcnt++;
            if (lat == inj_cycle) begin
                start_i   = inj_start;
                wr_en_i   = inj_wr;
                wr_addr_i = inj_addr;
                wr_data_i = inj_data;
            end
            @(posedge clk); #1;
            start_i = 1'b0;
            wr_en_i = 1'b0;
            lat++;
        end
        y = int'(y_o);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done_o); end
        checks++; if (y_o !== '0) begin failures++; $display("FAIL reset_y: got %0d expected 0", y_o); end
        checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    endtask

    task automatic test_basic();
        int y, lat, bcnt;
        logic [1:0] st1;
        load_all(1, 1);
        run_inf(16'h4321, -1, 1'b0, 1'b0, '0, '0, y, lat, bcnt, st1);
        checks++; if (y !== 80) begin failures++; $display("FAIL basic_y: got %0d expected 80", y); end
        checks++; if (lat !== 41) begin failures++; $display("FAIL basic_latency: got %0d expected 41", lat); end
        checks++; if (bcnt !== 40) begin failures++; $display("FAIL basic_busy_cycles: got %0d expected 40", bcnt); end
        checks++; if (st1 !== 2'd1) begin failures++; $display("FAIL basic_state_t1: got %0d expected 1", st1); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done: got %b expected 0", busy_o); end
        @(posedge clk); #1;
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL basic_done_pulse: got %b expected 0", done_o); end
        checks++; if (int'(y_o) !== 80) begin failures++; $display("FAIL basic_y_held: got %0d expected 80", y_o); end
    endtask

    task automatic test_negative();
        int y, lat, bcnt, exp_y;
        logic [1:0] st1;
`ifdef MLP_RELU_EN
        exp_y = 0;
`else
        exp_y = -80;
`endif
        load_all(-1, 1);
        run_inf(16'h4321, -1, 1'b0, 1'b0, '0, '0, y, lat, bcnt, st1);
        checks++; if (y !== exp_y) begin failures++; $display("FAIL negative_y: got %0d expected %0d", y, exp_y); end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        int y, lat, bcnt;
        logic [1:0] st1;
        load_all(15, 1);
        run_inf(16'hFFFF, -1, 1'b0, 1'b0, '0, '0, y, lat, bcnt, st1);
        checks++; if (y !== 4088) begin failures++; $display("FAIL sat_pos_y: got %0d expected 4088", y); end
        @(posedge clk); #1;
        for (int j = 0; j < N_HID; j++) write_w(N_IN*N_HID + j, -16);
        run_inf(16'hFFFF, -1, 1'b0, 1'b0, '0, '0, y, lat, bcnt, st1);
        checks++; if (y !== -65408) begin failures++; $display("FAIL sat_neg_y: got %0d expected -65408", y); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int y, lat, bcnt, exp_y;
        logic [1:0] st1;
        logic [15:0] xv;
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < N_W; a++) write_w(a, int'($urandom_range(0, 31)) - 16);
            xv = 16'($urandom);
            exp_y = model_y(xv);
            run_inf(xv, -1, 1'b0, 1'b0, '0, '0, y, lat, bcnt, st1);
            checks++; if (y !== exp_y) begin failures++; $display("FAIL random_y[%0d]: got %0d expected %0d", it, y, exp_y); end
            checks++; if (lat !== 41) begin failures++; $display("FAIL random_latency[%0d]: got %0d expected 41", it, lat); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_write_busy();
        int y, lat, bcnt;
        logic [1:0] st1;
        load_all(1, 1);
        run_inf(16'h4321, 3, 1'b0, 1'b1, 6'd32, 5'd15, y, lat, bcnt, st1);
        checks++; if (y !== 80) begin failures++; $display("FAIL wr_busy_y1: got %0d expected 80", y); end
        @(posedge clk); #1;
        run_inf(16'h4321, -1, 1'b0, 1'b0, '0, '0, y, lat, bcnt, st1);
        checks++; if (y !== 80) begin failures++; $display("FAIL wr_busy_y2: got %0d expected 80", y); end
        @(posedge clk); #1;
    endtask

    task automatic test_start_busy();
        int y, lat, bcnt;
        logic [1:0] st1;
        run_inf(16'h4321, 5, 1'b1, 1'b0, '0, '0, y, lat, bcnt, st1);
        checks++; if (lat !== 41) begin failures++; $display("FAIL start_busy_latency: got %0d expected 41", lat); end
        checks++; if (y !== 80) begin failures++; $display("FAIL start_busy_y: got %0d expected 80", y); end
        @(posedge clk); #1;
        checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL start_busy_idle: got %0d expected 0", state_o); end
    endtask

    task automatic test_out_of_range();
        int y, lat, bcnt, exp_y;
        logic [1:0] st1;
        for (int a = N_W; a < 64; a++) write_w(a, int'($urandom_range(0, 31)) - 16);
        exp_y = model_y(16'h4321);
        run_inf(16'h4321, -1, 1'b0, 1'b0, '0, '0, y, lat, bcnt, st1);
        checks++; if (y !== 80) begin failures++; $display("FAIL oor_y: got %0d expected 80", y); end
        checks++; if (y !== exp_y) begin failures++; $display("FAIL oor_model: got %0d expected %0d", y, exp_y); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        int y, lat, bcnt;
        logic [1:0] st1;
        x_i = 16'h4321;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        lat = 1;
        while (lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (state_o !== 2'd1) begin failures++; $display("FAIL mid_in_hid: got %0d expected 1", state_o); end
        rst_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b1;
        for (int a = 0; a < N_W; a++) wm[a] = 0;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL mid_rst_busy: got %b expected 0", busy_o); end
        checks++; if (y_o !== '0) begin failures++; $display("FAIL mid_rst_y: got %0d expected 0", y_o); end
        checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL mid_rst_state: got %0d expected 0", state_o); end
        run_inf(16'h4321, -1, 1'b0, 1'b0, '0, '0, y, lat, bcnt, st1);
        checks++; if (y !== 0) begin failures++; $display("FAIL mid_rst_rerun_y: got %0d expected 0", y); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int y, lat, bcnt;
        logic [1:0] st1;
        load_all(1, 1);
        run_inf(16'h4321, -1, 1'b0, 1'b0, '0, '0, y, lat, bcnt, st1);
        checks++; if (y !== 80) begin failures++; $display("FAIL b2b_first_y: got %0d expected 80", y); end
        @(posedge clk); #1;
        run_inf(16'h1000, -1, 1'b0, 1'b0, '0, '0, y, lat, bcnt, st1);
        checks++; if (y !== 8) begin failures++; $display("FAIL b2b_second_y: got %0d expected 8", y); end
        checks++; if (lat !== 41) begin failures++; $display("FAIL b2b_latency: got %0d expected 41", lat); end
        @(posedge clk); #1;
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_negative();
        test_saturation();
        test_random();
        test_write_busy();
        test_start_busy();
        test_out_of_range();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
